// File: rtl/sar_search_if.sv
// sar_search_if: bundle between the successive-approximation search controller
// and its environment (start request, comparator flags, search status/result).
//   start          : request a new search
//   g / e / l      : comparator relation flags (target >, ==, < probe)
//   probe          : candidate value presented to the comparator
//   busy / done    : search in progress / one-cycle termination pulse
//   found / result : hit indication and final probe of the last search
//   err            : last search aborted on invalid flags
// master = controller side, slave = environment/comparator side.
interface sar_search_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             g;
  logic             e;
  logic             l;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    input  start, g, e, l,
    output probe, busy, done, found, result, err
  );

  modport slave (
    output start, g, e, l,
    input  probe, busy, done, found, result, err
  );
endinterface

// File: rtl/sar_search.sv
// sar_search: successive-approximation search controller. Drives a candidate
// value to an external magnitude comparator, reads back its g/e/l flags and
// narrows a [lo, hi] window each cycle until the comparand is hit or the
// window is proven empty.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : sar_search_if.master (start, g/e/l in; probe, busy, done, found,
//          result, err out)
//
// Optional feature macro: SAR_SEARCH_ERRCHK_EN
//   defined     : non-one-hot comparator flags abort the search with err=1
//   not defined : flags resolved by priority e > g > l (none set acts as l),
//                 err tied to 0
//
// state | meaning
// IDLE  | waiting for start; outputs of the last search held
// PROBE | probe valid, sampling comparator flags every cycle
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  sar_search_if.master bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] RANGE_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] FIRST_PROBE = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] result_q, result_d;
`ifdef SAR_SEARCH_ERRCHK_EN
  logic             err_q, err_d;
`endif

  // Resolved comparator relation for the current probe.
  logic flag_hit;
  logic flag_up;
  logic flag_down;
  logic flag_bad;

  // Midpoint of the narrowed window, one bit wider so hi-lo never wraps.
  logic             narrow;
  logic [WIDTH:0]   mid_w;

  always_comb begin
    flag_hit  = 1'b0;
    flag_up   = 1'b0;
    flag_down = 1'b0;
    flag_bad  = 1'b0;
`ifdef SAR_SEARCH_ERRCHK_EN
    case ({bus.g, bus.e, bus.l})
      3'b100:  flag_up   = 1'b1;
      3'b010:  flag_hit  = 1'b1;
      3'b001:  flag_down = 1'b1;
      default: flag_bad  = 1'b1;
    endcase
`else
    if (bus.e) begin
      flag_hit = 1'b1;
    end else if (bus.g) begin
      flag_up = 1'b1;
    end else begin
      flag_down = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probe_d  = probe_q;
    done_d   = 1'b0;
    found_d  = found_q;
    result_d = result_q;
`ifdef SAR_SEARCH_ERRCHK_EN
    err_d    = err_q;
`endif
    narrow   = 1'b0;
    mid_w    = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          lo_d    = '0;
          hi_d    = RANGE_MAX;
          probe_d = FIRST_PROBE;
          found_d = 1'b0;
`ifdef SAR_SEARCH_ERRCHK_EN
          err_d   = 1'b0;
`endif
          state_d = PROBE;
        end
      end

      PROBE: begin
        if (flag_bad) begin
`ifdef SAR_SEARCH_ERRCHK_EN
          err_d    = 1'b1;
`endif
          found_d  = 1'b0;
          result_d = probe_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (flag_hit) begin
          found_d  = 1'b1;
          result_d = probe_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if ((flag_up && probe_q == hi_q) || (flag_down && probe_q == lo_q)) begin
          // Window exhausted; also keeps lo from overflowing and hi from underflowing.
          found_d  = 1'b0;
          result_d = probe_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (flag_up) begin
          lo_d   = probe_q + 1'b1;
          narrow = 1'b1;
        end else begin
          hi_d   = probe_q - 1'b1;
          narrow = 1'b1;
        end

        if (narrow) begin
          mid_w   = {1'b0, lo_d} + (({1'b0, hi_d} - {1'b0, lo_d}) >> 1);
          probe_d = mid_w[WIDTH-1:0];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      result_q <= '0;
`ifdef SAR_SEARCH_ERRCHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_q  <= probe_d;
      done_q   <= done_d;
      found_q  <= found_d;
      result_q <= result_d;
`ifdef SAR_SEARCH_ERRCHK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign bus.probe  = probe_q;
  assign bus.busy   = (state_q == PROBE);
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.result = result_q;
`ifdef SAR_SEARCH_ERRCHK_EN
  assign bus.err    = err_q;
`else
  assign bus.err    = 1'b0;
`endif

endmodule
